adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//   Parametrised, pipelined adder/accumulator with valid/ready handshake on both sides.
//   Supports add, subtract, accumulate and accumulator-load modes, signed or unsigned operands,
//   and a wrap or saturate policy on the accumulator.
//   It sits between a streaming producer and consumer in the datapath and is the general
//   replacement for the plain combinational adder.
// PARAMETERS
//   C_DATA_WIDTH   4                   operand width, range 2..32
//   C_ACC_WIDTH    C_DATA_WIDTH+4      accumulator/result width, must be >= C_DATA_WIDTH+1
//   C_PIPE_STAGES  2                   input-to-output latency in cycles, range 1..4
//   C_SIGNED       0                   1: operands two's complement; 0: unsigned
//   C_SAT          1                   1: accumulator saturates on overflow; 0: wraps
// PORTS
//   I_sys_clk  in   1             system clock
//   I_rst_n    in   1             asynchronous reset, active low
//   I_valid    in   1             input beat valid
//   O_ready    out  1             block accepts a beat this cycle
//   I_mode     in   2             00 A+B, 01 A-B, 10 ACC+=A+B, 11 ACC=A+B
//   I_a        in   C_DATA_WIDTH  operand A
//   I_b        in   C_DATA_WIDTH  operand B
//   O_valid    out  1             output beat valid
//   I_ready    in   1             downstream accepts output
//   O_sum      out  C_ACC_WIDTH   result, sign- or zero-extended per C_SIGNED
//   O_ovf      out  1             overflow/borrow flag for this beat
// BEHAVIOUR
//   Clock and reset: single clock I_sys_clk. Reset is asynchronous and active-low on I_rst_n.
//   Reset values: O_valid=0, O_sum=0, O_ovf=0, accumulator=0, all pipeline valid bits=0.
//     O_ready=1 from the first cycle after reset release.
//   Handshake:
//     - Input accepted when I_valid && O_ready.
//     - Output transferred when O_valid && I_ready.
//     - O_sum and O_ovf hold stable while O_valid && !I_ready.
//   Pipeline: C_PIPE_STAGES register stages with a global advance = !O_valid || I_ready.
//     - O_ready = advance; the whole pipe stalls together.
//     - A bubble in a stage is not compressed.
//     - Latency is exactly C_PIPE_STAGES cycles when there is no stall.
//     - Full throughput of 1 beat/cycle; no beat is lost or reordered under any I_ready pattern.
//   Arithmetic: operands are extended to C_ACC_WIDTH (sign-extended if C_SIGNED, else zero).
//     - 00: sum = A+B; O_ovf=0 (cannot overflow in C_ACC_WIDTH).
//     - 01: diff = A-B. Unsigned: two's-complement result, O_ovf=1 on borrow (A<B).
//       Signed: O_ovf=0.
//     - 10: ACC_next = ACC + (A+B), computed at accept time, so back-to-back accumulate
//       beats chain correctly.
//       Unsigned overflow: result > 2^C_ACC_WIDTH-1. Signed overflow: result outside
//       the C_ACC_WIDTH two's-complement range.
//       On overflow: O_ovf=1; C_SAT=1 clamps ACC to max/min, C_SAT=0 keeps the wrapped value.
//       O_sum = ACC_next.
//     - 11: ACC_next = A+B; O_sum = ACC_next; O_ovf=0.
//   Accumulator is updated only on an accepted beat in mode 10 or 11. Modes 00/01 leave it untouched.
//   Reset mid-operation: in-flight beats are discarded, ACC is cleared, and O_valid drops
//     asynchronously. No partial beat appears after release.
//   Unknown/illegal parameter combos are rejected by an elaboration-time check.
// TESTING (C_DATA_WIDTH=4, C_ACC_WIDTH=8, C_PIPE_STAGES=2 unless stated)
//   1. Unsigned mode 00, A=4'hF, B=4'hF, I_ready=1 -> O_valid 2 cycles later, O_sum=8'h1E, O_ovf=0.
//   2. Unsigned mode 01, A=3, B=5 -> O_sum=8'hFE, O_ovf=1. Then A=5, B=3 -> O_sum=8'h02, O_ovf=0.
//   3. Mode 11 A=10,B=5 (ACC=15), then nine back-to-back mode 10 beats A=15,B=15:
//      - O_sum = 45, 75, ..., 255, with O_ovf=0 throughout.
//      - Ninth beat: C_SAT=1 -> 255, O_ovf=1; C_SAT=0 -> 29, O_ovf=1.
//   4. Stream 4 add beats, hold I_ready=0 for 3 cycles mid-stream:
//      - O_ready=0 while the pipe is full.
//      - O_sum/O_valid stay stable during the stall.
//      - All 4 results are delivered in order with no duplicates.
//   5. C_SIGNED=1, mode 00, A=-8, B=-8 -> O_sum=8'hF0.
//      Mode 10 from ACC=-120 with A=-8,B=-8 -> C_SAT=1 gives O_sum=8'h80 (-128), O_ovf=1.
//   6. Assert I_rst_n=0 asynchronously with 2 beats in flight:
//      - O_valid=0 immediately.
//      - After release, O_ready=1, ACC=0, and mode 10 with A=1,B=1 yields O_sum=2.

Source files
------------

// File: rtl/adder_pipe.sv
// Pipelined adder/accumulator with a valid/ready handshake on both sides.
// The result is computed at accept time and then carried through C_PIPE_STAGES registers.
module adder_pipe #(
    parameter int C_DATA_WIDTH  = 4,
    parameter int C_ACC_WIDTH   = C_DATA_WIDTH + 4,
    parameter int C_PIPE_STAGES = 2,
    parameter int C_SIGNED      = 0,
    parameter int C_SAT         = 1
) (
    input  logic                    I_sys_clk,
    input  logic                    I_rst_n,
    input  logic                    I_valid,
    output logic                    O_ready,
    input  logic [1:0]              I_mode,
    input  logic [C_DATA_WIDTH-1:0] I_a,
    input  logic [C_DATA_WIDTH-1:0] I_b,
    output logic                    O_valid,
    input  logic                    I_ready,
    output logic [C_ACC_WIDTH-1:0]  O_sum,
    output logic                    O_ovf
);

    localparam int AW = C_ACC_WIDTH;
    localparam int XW = C_ACC_WIDTH + 2;
    localparam int NS = C_PIPE_STAGES;

    generate
        if (C_DATA_WIDTH < 2 || C_DATA_WIDTH > 32 || C_ACC_WIDTH < C_DATA_WIDTH + 1 ||
            C_PIPE_STAGES < 1 || C_PIPE_STAGES > 4 ||
            (C_SIGNED != 0 && C_SIGNED != 1) || (C_SAT != 0 && C_SAT != 1)) begin : g_bad_params
            $error("adder_pipe: illegal parameter combination");
        end
    endgenerate

    // Handshake: a beat is accepted when I_valid && O_ready, and delivered when
    // O_valid && I_ready. The whole pipe advances together whenever the last
    // stage is empty or being drained, so O_ready equals that advance signal.
    logic          advance;
    logic          accept;

    logic [XW-1:0] a_x;
    logic [XW-1:0] b_x;
    logic [XW-1:0] acc_x;
    logic [XW-1:0] ab_x;
    logic [XW-1:0] accsum_x;
    logic [AW:0]   diff_x;
    logic          acc_ovf;
    logic [AW-1:0] clamp;
    logic [AW-1:0] res;
    logic          res_ovf;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic          vld_q [NS];
    logic          vld_d [NS];
    logic [AW-1:0] sum_q [NS];
    logic [AW-1:0] sum_d [NS];
    logic          ovf_q [NS];
    logic          ovf_d [NS];

    assign advance = !vld_q[NS-1] || I_ready;
    assign accept  = I_valid && advance;

    // Two guard bits above the accumulator width expose both unsigned carry-out
    // and signed overflow of ACC + (A+B) without a separate carry chain.
    always_comb begin
        a_x      = (C_SIGNED != 0) ? XW'($signed(I_a))   : XW'(I_a);
        b_x      = (C_SIGNED != 0) ? XW'($signed(I_b))   : XW'(I_b);
        acc_x    = (C_SIGNED != 0) ? XW'($signed(acc_q)) : XW'(acc_q);
        ab_x     = a_x + b_x;
        diff_x   = a_x[AW:0] - b_x[AW:0];
        accsum_x = acc_x + ab_x;

        if (C_SIGNED != 0) begin
            acc_ovf = (accsum_x[XW-1:AW-1] != '0) && (accsum_x[XW-1:AW-1] != '1);
            clamp   = accsum_x[XW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            acc_ovf = (accsum_x[XW-1:AW] != '0);
            clamp   = '1;
        end

        res     = ab_x[AW-1:0];
        res_ovf = 1'b0;
        case (I_mode)
            2'b01: begin
                res     = diff_x[AW-1:0];
                res_ovf = (C_SIGNED == 0) && diff_x[AW];
            end
            2'b10: begin
                res     = ((C_SAT != 0) && acc_ovf) ? clamp : accsum_x[AW-1:0];
                res_ovf = acc_ovf;
            end
            default: begin
                res     = ab_x[AW-1:0];
                res_ovf = 1'b0;
            end
        endcase

        acc_d = acc_q;
        if (accept && I_mode[1]) begin
            acc_d = res;
        end
    end

    // Bubbles move with the data; nothing is compressed while the pipe advances.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            vld_d[i] = vld_q[i];
            sum_d[i] = sum_q[i];
            ovf_d[i] = ovf_q[i];
        end
        if (advance) begin
            vld_d[0] = I_valid;
            sum_d[0] = res;
            ovf_d[0] = res_ovf;
            for (int i = 1; i < NS; i++) begin
                vld_d[i] = vld_q[i-1];
                sum_d[i] = sum_q[i-1];
                ovf_d[i] = ovf_q[i-1];
            end
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            acc_q <= '0;
            for (int i = 0; i < NS; i++) begin
                vld_q[i] <= 1'b0;
                sum_q[i] <= '0;
                ovf_q[i] <= 1'b0;
            end
        end else begin
            acc_q <= acc_d;
            for (int i = 0; i < NS; i++) begin
                vld_q[i] <= vld_d[i];
                sum_q[i] <= sum_d[i];
                ovf_q[i] <= ovf_d[i];
            end
        end
    end

    assign O_ready = advance;
    assign O_valid = vld_q[NS-1];
    assign O_sum   = sum_q[NS-1];
    assign O_ovf   = ovf_q[NS-1];

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: unsigned-saturating, unsigned-wrapping and
// signed-saturating instances share one stimulus stream; expectations are {ovf, sum}.
module tb_adder_pipe;

    localparam int DW = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [1:0]    mode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          rdy;

    logic          u_ready, w_ready, s_ready;
    logic          u_valid, w_valid, s_valid;
    logic [AW-1:0] u_sum, w_sum, s_sum;
    logic          u_ovf, w_ovf, s_ovf;

    logic [AW:0]   exp_q[$];
    logic [AW:0]   exp_w_q[$];
    logic [AW:0]   exp_s_q[$];
    logic [AW:0]   nxt_u, nxt_w, nxt_s;
    bit            chk_u, chk_w, chk_s;
    int            n_vec = 0;
    int            n_err = 0;

    logic [AW:0]   t3_u [9] = '{9'h02D, 9'h04B, 9'h069, 9'h087, 9'h0A5, 9'h0C3, 9'h0E1, 9'h0FF, 9'h1FF};
    logic [AW:0]   t3_w [9] = '{9'h02D, 9'h04B, 9'h069, 9'h087, 9'h0A5, 9'h0C3, 9'h0E1, 9'h0FF, 9'h11D};
    logic [AW:0]   t3_s [9] = '{9'h0FD, 9'h0FB, 9'h0F9, 9'h0F7, 9'h0F5, 9'h0F3, 9'h0F1, 9'h0EF, 9'h0ED};
    logic [AW:0]   t5_s [6] = '{9'h0E0, 9'h0D0, 9'h0C0, 9'h0B0, 9'h0A0, 9'h090};

    always #5 clk = ~clk;

    adder_pipe #(.C_DATA_WIDTH(DW), .C_ACC_WIDTH(AW), .C_PIPE_STAGES(2), .C_SIGNED(0), .C_SAT(1)) u_dut_u (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_valid(valid), .O_ready(u_ready), .I_mode(mode),
        .I_a(a), .I_b(b), .O_valid(u_valid), .I_ready(rdy), .O_sum(u_sum), .O_ovf(u_ovf)
    );

    adder_pipe #(.C_DATA_WIDTH(DW), .C_ACC_WIDTH(AW), .C_PIPE_STAGES(2), .C_SIGNED(0), .C_SAT(0)) u_dut_w (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_valid(valid), .O_ready(w_ready), .I_mode(mode),
        .I_a(a), .I_b(b), .O_valid(w_valid), .I_ready(rdy), .O_sum(w_sum), .O_ovf(w_ovf)
    );

    adder_pipe #(.C_DATA_WIDTH(DW), .C_ACC_WIDTH(AW), .C_PIPE_STAGES(2), .C_SIGNED(1), .C_SAT(1)) u_dut_s (
        .I_sys_clk(clk), .I_rst_n(rst_n), .I_valid(valid), .O_ready(s_ready), .I_mode(mode),
        .I_a(a), .I_b(b), .O_valid(s_valid), .I_ready(rdy), .O_sum(s_sum), .O_ovf(s_ovf)
    );

    task automatic check(input string tag, input logic [AW:0] obs, input logic [AW:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record an accepted beat, score a delivered beat, then step past the edge.
    task automatic tick();
        logic [AW:0] eu, ew, es;
        #1;
        if (valid && u_ready) begin
            exp_q.push_back(nxt_u);
            exp_w_q.push_back(nxt_w);
            exp_s_q.push_back(nxt_s);
        end
        if (u_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {8'h00, u_valid}, 9'h000);
            end else begin
                eu = exp_q.pop_front();
                ew = exp_w_q.pop_front();
                es = exp_s_q.pop_front();
                if (chk_u) check("out_unsigned_sat", {u_ovf, u_sum}, eu);
                if (chk_w) check("out_unsigned_wrap", {w_ovf, w_sum}, ew);
                if (chk_s) check("out_signed_sat", {s_ovf, s_sum}, es);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] m, input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                        input logic [AW:0] eu, input logic [AW:0] ew, input logic [AW:0] es);
        valid = 1'b1;
        mode  = m;
        a     = ia;
        b     = ib;
        nxt_u = eu;
        nxt_w = ew;
        nxt_s = es;
        tick();
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_pending", 9'(exp_q.size()), 9'h000);
        check("idle_after_drain", {8'h00, u_valid}, 9'h000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        mode  = 2'b00;
        a     = '0;
        b     = '0;
        rdy   = 1'b1;
        nxt_u = '0;
        nxt_w = '0;
        nxt_s = '0;
        chk_u = 1'b1;
        chk_w = 1'b1;
        chk_s = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {8'h00, u_valid}, 9'h000);
        check("rst_sum_ovf", {u_ovf, u_sum}, 9'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", {8'h00, u_ready}, 9'h001);

        // Unsigned add, two-cycle latency
        beat(2'b00, 4'hF, 4'hF, 9'h01E, 9'h01E, 9'h0FE);
        valid = 1'b0;
        check("latency_cycle1", {8'h00, u_valid}, 9'h000);
        tick();
        check("latency_cycle2", {8'h00, u_valid}, 9'h001);
        drain();

        // Subtract with and without borrow
        beat(2'b01, 4'd3, 4'd5, 9'h1FE, 9'h1FE, 9'h0FE);
        beat(2'b01, 4'd5, 4'd3, 9'h002, 9'h002, 9'h002);
        valid = 1'b0;
        drain();

        // Load then nine back-to-back accumulates into the ceiling
        beat(2'b11, 4'd10, 4'd5, 9'h00F, 9'h00F, 9'h0FF);
        for (int k = 0; k < 9; k++) begin
            beat(2'b10, 4'hF, 4'hF, t3_u[k], t3_w[k], t3_s[k]);
        end
        valid = 1'b0;
        drain();

        // A plain add must leave the accumulator alone
        beat(2'b00, 4'd1, 4'd1, 9'h002, 9'h002, 9'h002);
        beat(2'b10, 4'd0, 4'd0, 9'h0FF, 9'h01D, 9'h0ED);
        valid = 1'b0;
        drain();

        // Stream of four adds with a three-cycle downstream stall
        beat(2'b00, 4'd1, 4'd2, 9'h003, 9'h003, 9'h003);
        beat(2'b00, 4'd3, 4'd4, 9'h007, 9'h007, 9'h007);
        valid = 1'b1;
        mode  = 2'b00;
        a     = 4'd5;
        b     = 4'd6;
        nxt_u = 9'h00B;
        nxt_w = 9'h00B;
        nxt_s = 9'h00B;
        rdy   = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("stall_ready", {8'h00, u_ready}, 9'h000);
            check("stall_valid", {8'h00, u_valid}, 9'h001);
            check("stall_hold", {u_ovf, u_sum}, 9'h003);
            tick();
        end
        rdy = 1'b1;
        tick();
        beat(2'b00, 4'd7, 4'd8, 9'h00F, 9'h00F, 9'h0FF);
        valid = 1'b0;
        drain();

        // Signed add and saturation at the negative limit
        chk_u = 1'b0;
        chk_w = 1'b0;
        beat(2'b00, 4'h8, 4'h8, 9'h000, 9'h000, 9'h0F0);
        beat(2'b11, 4'h8, 4'h8, 9'h000, 9'h000, 9'h0F0);
        for (int k = 0; k < 6; k++) begin
            beat(2'b10, 4'h8, 4'h8, 9'h000, 9'h000, t5_s[k]);
        end
        beat(2'b10, 4'h8, 4'h0, 9'h000, 9'h000, 9'h088);
        beat(2'b10, 4'h8, 4'h8, 9'h000, 9'h000, 9'h180);
        valid = 1'b0;
        drain();
        chk_u = 1'b1;
        chk_w = 1'b1;

        // Asynchronous reset with two beats in flight
        beat(2'b00, 4'd1, 4'd2, 9'h003, 9'h003, 9'h003);
        beat(2'b00, 4'd3, 4'd4, 9'h007, 9'h007, 9'h007);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_u", {8'h00, u_valid}, 9'h000);
        check("async_rst_valid_w", {8'h00, w_valid}, 9'h000);
        check("async_rst_valid_s", {8'h00, s_valid}, 9'h000);
        exp_q.delete();
        exp_w_q.delete();
        exp_s_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {8'h00, u_ready}, 9'h001);
        check("post_rst_sum", {u_ovf, u_sum}, 9'h000);
        beat(2'b10, 4'd1, 4'd1, 9'h002, 9'h002, 9'h002);
        valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
